// File: rtl/fp_acc_pkg.sv
// Shared definitions for the fp_acc accumulator: float field layout, gray-coded
// FSM states and small float field-slice helpers.
`define GRAY(b) ((b) ^ ((b) >> 1))

package fp_acc_pkg;

   localparam int FP_MSB      = 31;
   localparam int FP_FMSB     = 22;
   localparam int ACC_CW      = 8;
   localparam int ACC_TMO_CYC = 64;

   // Exponent sits between the sign bit and the fraction field.
   localparam int EMSB = FP_MSB - 1;
   localparam int ELSB = FP_FMSB + 1;
   localparam int EW   = EMSB - ELSB + 1;
   localparam logic [EW-1:0] EMSK = '1;

   typedef enum logic [3:0] {
      S_EMPTY   = `GRAY(4'd0),
      S_PART    = `GRAY(4'd1),
      S_WAIT_LO = `GRAY(4'd2),
      S_WAIT_HI = `GRAY(4'd3),
      S_OUT     = `GRAY(4'd4)
   } acc_state_e;

   function automatic logic f_sign(input logic [FP_MSB:0] f);
      return f[FP_MSB];
   endfunction

   function automatic logic [EW-1:0] f_exp(input logic [FP_MSB:0] f);
      return f[EMSB:ELSB];
   endfunction

   function automatic logic [FP_FMSB:0] f_frac(input logic [FP_MSB:0] f);
      return f[FP_FMSB:0];
   endfunction

   function automatic logic f_is_special(input logic [FP_MSB:0] f);
      return f_exp(f) == EMSK;
   endfunction

endpackage

// File: rtl/fp_req_tgl.sv
// Toggle-request driver for fp_add: owns the req toggle, tracks ack going low
// then high again, and times out a stalled operation.
module fp_req_tgl
   import fp_acc_pkg::*;
#(
   parameter int TMO_CYC = ACC_TMO_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic start,
   input  logic add_ack,
   output logic add_req,
   output logic ack_lo,
   output logic done,
   output logic timeout
);

   localparam int TW = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {PH_IDLE, PH_LO, PH_HI} phase_e;

   phase_e        phase_q, phase_d;
   logic          req_q, req_d;
   logic [TW-1:0] tmr_q, tmr_d;

   assign add_req = req_q;
   assign ack_lo  = (phase_q == PH_LO) && !add_ack;
   assign done    = (phase_q == PH_HI) && add_ack;
   assign timeout = (phase_q != PH_IDLE) && (tmr_q == TW'(TMO_CYC - 1));

   always_comb begin
      phase_d = phase_q;
      req_d   = req_q;
      tmr_d   = tmr_q;
      if (start) begin
         req_d   = ~req_q;
         tmr_d   = '0;
         phase_d = PH_LO;
      end else if (phase_q != PH_IDLE) begin
         tmr_d = tmr_q + 1'b1;
         if (done || timeout)
            phase_d = PH_IDLE;
         else if (ack_lo)
            phase_d = PH_HI;
      end
      // The request level is held across disable so fp_add sees no new edge.
      if (!enable) begin
         phase_d = PH_IDLE;
         tmr_d   = '0;
         req_d   = req_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values computed in always_comb before any of them update.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_IDLE;
         req_q   <= 1'b0;
         tmr_q   <= '0;
      end else begin
         phase_q <= phase_d;
         req_q   <= req_d;
         tmr_q   <= tmr_d;
      end
   end

endmodule

// File: rtl/fp_acc.sv
// Streaming float accumulator: sums each operand group through fp_add and
// emits one sum, operand count and timeout flag per group.
module fp_acc
   import fp_acc_pkg::*;
#(
   parameter int MSB     = FP_MSB,
   parameter int FMSB    = FP_FMSB,
   parameter int CW      = ACC_CW,
   parameter int TMO_CYC = ACC_TMO_CYC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MSB:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [MSB:0]  out_data,
   output logic [CW-1:0] out_count,
   output logic          out_err,
   output logic          add_req,
   input  logic          add_ack,
   output logic [MSB:0]  add_op1,
   output logic [MSB:0]  add_op2,
   input  logic [MSB:0]  add_res
);

   if (FMSB >= MSB - 1) begin : g_bad_fmsb
      $error("fp_acc: FMSB must leave room for sign and exponent");
   end

   acc_state_e    state_q, state_d;
   logic [MSB:0]  acc_q, acc_d;
   logic [MSB:0]  op1_q, op1_d;
   logic [MSB:0]  op2_q, op2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          last_q, last_d;
   logic          start, ack_lo, done, timeout, in_fire;

   assign in_ready  = enable && !rst && (state_q == S_EMPTY || state_q == S_PART);
   assign in_fire   = in_valid && in_ready;
   assign out_valid = (state_q == S_OUT);
   assign out_data  = acc_q;
   assign out_count = cnt_q;
   assign out_err   = err_q;
   assign add_op1   = op1_q;
   assign add_op2   = op2_q;

   fp_req_tgl #(.TMO_CYC(TMO_CYC)) u_req_tgl (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .start   (start),
      .add_ack (add_ack),
      .add_req (add_req),
      .ack_lo  (ack_lo),
      .done    (done),
      .timeout (timeout)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      last_d  = last_q;
      start   = 1'b0;
      case (state_q)
         S_EMPTY: if (in_fire) begin
            acc_d   = in_data;
            cnt_d   = CW'(1);
            err_d   = 1'b0;
            state_d = in_last ? S_OUT : S_PART;
         end
         S_PART: if (in_fire) begin
            op1_d   = acc_q;
            op2_d   = in_data;
            last_d  = in_last;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            start   = 1'b1;
            state_d = S_WAIT_LO;
         end
         S_WAIT_LO: if (timeout) begin
            err_d   = 1'b1;
            state_d = S_OUT;
         end else if (ack_lo) begin
            state_d = S_WAIT_HI;
         end
         // A completed result wins over a timeout landing on the same cycle.
         S_WAIT_HI: if (done) begin
            acc_d   = add_res;
            state_d = last_q ? S_OUT : S_PART;
         end else if (timeout) begin
            err_d   = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: if (out_ready) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
      if (!enable) begin
         state_d = S_EMPTY;
         start   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         acc_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_fp_acc.sv
// Self-checking bench for fp_acc with a behavioural fp_add model and a
// real-arithmetic reference sum per group.
module tb_fp_acc;

   localparam int TMO    = 64;
   localparam int BUDGET = 500;

   logic        clk = 1'b0;
   logic        rst, enable, in_valid, in_ready, in_last;
   logic [31:0] in_data, out_data, add_op1, add_op2, add_res;
   logic        out_valid, out_ready, out_err, add_req, add_ack;
   logic [7:0]  out_count;

   int checks = 0, failures = 0;
   int starts = 0, proto_err = 0, toggles = 0;
   int fixed_lat = 0;
   bit stuck = 1'b0;

   fp_acc #(.MSB(31), .FMSB(22), .CW(8), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_err(out_err),
      .add_req(add_req), .add_ack(add_ack), .add_op1(add_op1), .add_op2(add_op2),
      .add_res(add_res)
   );

   always #5 clk = ~clk;

   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:0] == 31'd0) return 0.0;
      e = 11'(f[30:23]) + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      logic [7:0]  e;
      if (r == 0.0) return 32'd0;
      b = $realtobits(r);
      e = 8'(b[62:52] - 11'd896);
      return {b[63], e, b[51:29]};
   endfunction

   // Behavioural fp_add: toggle-req start, ack low while busy, result one
   // cycle before ack returns high.
   logic        seen;
   logic        busy;
   int          lat;
   logic [31:0] pend;
   always @(posedge clk) begin
      if (rst) begin
         add_ack <= 1'b1; add_res <= 32'd0; busy <= 1'b0; seen <= 1'b0; lat <= 0;
      end else if (!enable) begin
         add_ack <= 1'b1; busy <= 1'b0; lat <= 0;
      end else if (!busy) begin
         if (add_req !== seen) begin
            seen    <= add_req;
            busy    <= 1'b1;
            add_ack <= 1'b0;
            starts  <= starts + 1;
            lat     <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
            pend    <= r2f(f2r(add_op1) + f2r(add_op2));
         end
      end else begin
         if (add_req !== seen) proto_err <= proto_err + 1;
         if (!stuck) begin
            if (lat == 1) begin add_res <= pend; lat <= 0; end
            else if (lat == 0) begin add_ack <= 1'b1; busy <= 1'b0; end
            else lat <= lat - 1;
         end
      end
   end

   logic req_prev;
   always @(posedge clk) begin
      req_prev <= add_req;
      if (add_req !== req_prev) toggles <= toggles + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [31:0] d, input bit last);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      while (!in_ready && n < BUDGET) begin @(negedge clk); n++; end
      if (n >= BUDGET) check("send accept", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (!out_valid && n < BUDGET) begin @(negedge clk); n++; end
      check({tag, " valid"}, 64'(n < BUDGET), 1);
   endtask

   task automatic recv(input string tag, input logic [31:0] d, input int c, input bit e);
      int n;
      wait_valid(tag, n);
      check({tag, " data"}, out_data, d);
      check({tag, " count"}, out_count, c);
      check({tag, " err"}, out_err, e);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t0, s0, n, len, k;
      bit  ok, req0;
      real v, sum;

      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_data", out_data, 0);
      check("rst out_count", out_count, 0);
      check("rst out_err", out_err, 0);
      check("rst add_req", add_req, 0);
      check("rst add_op1", add_op1, 0);
      check("rst add_op2", add_op2, 0);
      rst = 1'b0;
      #1;
      check("post rst in_ready", in_ready, 1);
      @(negedge clk);

      // Single operand group: stored directly, never sent to the adder.
      t0 = toggles;
      send(32'h3FC00000, 1'b1);
      check("single latency", out_valid, 1);
      recv("single", 32'h3FC00000, 1, 0);
      check("single toggles", toggles - t0, 0);

      t0 = toggles;
      send(32'h3FC00000, 1'b0);
      send(32'h40000000, 1'b0);
      send(32'h3F000000, 1'b1);
      recv("three", 32'h40800000, 3, 0);
      check("three toggles", toggles - t0, 2);

      // Output back-pressure.
      send(32'h3F800000, 1'b0);
      send(32'h3F800000, 1'b1);
      wait_valid("bp", n);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!(out_valid && out_data == 32'h40000000 && !in_ready)) ok = 1'b0;
      end
      check("bp hold", ok, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp release valid", out_valid, 0);
      check("bp release ready", in_ready, 1);

      // Randomised groups against a real-valued running sum.
      for (int g = 0; g < 20; g++) begin
         len = $urandom_range(1, 6);
         sum = 0.0;
         for (int i = 0; i < len; i++) begin
            k = $urandom_range(1, 64);
            v = k * 0.5;
            if ($urandom_range(0, 3) == 0) v = -v;
            sum += v;
            send(r2f(v), i == len - 1);
         end
         recv("rnd", r2f(sum), len, 0);
      end

      // Operand count saturates at 255.
      for (int i = 0; i < 260; i++) send(32'h3F800000, i == 259);
      recv("sat", r2f(260.0), 255, 0);

      // Adder never returns ack: timeout after TMO cycles with acc unchanged.
      stuck = 1'b1;
      send(32'h40400000, 1'b0);
      t0 = toggles;
      send(32'h3F800000, 1'b1);
      wait_valid("tmo", n);
      check("tmo cycles", n, TMO);
      recv("tmo", 32'h40400000, 2, 1);
      check("tmo toggles", toggles - t0, 1);

      stuck = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Disable while waiting for ack high, then re-enable.
      fixed_lat = 8;
      send(32'h3F800000, 1'b0);
      send(32'h3F800000, 1'b1);
      repeat (3) @(negedge clk);
      req0 = add_req;
      s0   = starts;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("dis out_valid", out_valid, 0);
      check("dis in_ready", in_ready, 0);
      check("dis add_req", add_req, req0);
      enable = 1'b1;
      #1;
      check("reen in_ready", in_ready, 1);
      repeat (12) @(negedge clk);
      check("reen out_valid", out_valid, 0);
      check("reen add_req", add_req, req0);
      check("reen no start", starts - s0, 0);
      fixed_lat = 0;

      // Reset mid-group.
      send(32'h3F800000, 1'b0);
      send(32'h3F800000, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid rst out_valid", out_valid, 0);
      check("mid rst out_data", out_data, 0);
      check("mid rst out_count", out_count, 0);
      check("mid rst out_err", out_err, 0);
      check("mid rst add_req", add_req, 0);
      check("mid rst add_op1", add_op1, 0);
      check("mid rst add_op2", add_op2, 0);
      check("mid rst in_ready", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      send(32'h40000000, 1'b0);
      send(32'h40000000, 1'b1);
      recv("after rst", 32'h40800000, 2, 0);

      check("one outstanding op", proto_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
